baud_tick_gen: RTL
==================

Name: baud_tick_gen

Overview:
Parametrised UART baud timing generator that replaces the fixed-divisor baud generator.
- Produces a 1-cycle oversample tick, a bit-rate tick and a mid-bit sample tick.
- Divisor is runtime-loadable and glitch-free; phase can be resynchronised for RX start-bit alignment.
- Sits between the system clock and the UART TX/RX shifters. All outputs are single-cycle enables, not derived clocks.

Parameters:
DIV_W, 16, width of the oversample divisor.
OVERSAMPLE, 16, oversample ticks per bit (power of two, 4..64).
DEFAULT_DIV, 651, reset divisor (100 MHz / (9600 * 16)).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  count enable
div_in  in  DIV_W  new divisor value
div_load  in  1  1-cycle strobe: stage div_in
resync  in  1  1-cycle strobe: restart bit phase (RX start-bit edge)
os_tick  out  1  oversample tick, 1-cycle pulse
bit_tick  out  1  bit-rate tick, 1-cycle pulse, coincident with os_tick
mid_tick  out  1  mid-bit tick, 1-cycle pulse, coincident with os_tick
div_cur  out  DIV_W  divisor currently in effect

Behaviour:
Reset (rst=1 at a clk edge):
- cnt=0, os_cnt=0, div_act=DEFAULT_DIV, div_pend=DEFAULT_DIV, pend_valid=0.
- os_tick=0, bit_tick=0, mid_tick=0, div_cur=DEFAULT_DIV.
- rst has priority over every other input.

Prescaler (all outputs registered):
- Each edge with en=1: if cnt==div_act-1, then cnt<=0 and os_tick<=1; else cnt<=cnt+1 and os_tick<=0.
- With en held high from reset release, os_tick is high after edge div_act, 2*div_act, and so on; period is exactly div_act cycles.
- en=0: cnt and os_cnt hold; all tick outputs are 0 on the next edge.

Oversample counter os_cnt (log2(OVERSAMPLE) bits):
- Advances on every prescaler wrap; wraps from OVERSAMPLE-1 to 0.
- bit_tick<=1 on the wrap where os_cnt==OVERSAMPLE-1.
- mid_tick<=1 on the wrap where os_cnt==OVERSAMPLE/2-1.
- Both are high in the same cycle as the matching os_tick, never otherwise.

Divisor load:
- div_load=1: div_pend<=max(div_in,2) and pend_valid<=1. Values 0 and 1 clamp to 2.
- A pending divisor is applied (div_act<=div_pend, pend_valid<=0) on the next prescaler wrap, so the current period always completes at the old divisor.
- A second div_load before the wrap overwrites div_pend.
- div_cur reflects div_act.

Resync:
- resync=1: cnt<=0, os_cnt<=0, all ticks 0 that edge.
- Any pending divisor is applied immediately.
- resync acts regardless of en.
- If resync and div_load occur in the same cycle, the newly presented div_in (clamped) becomes div_act immediately.
- resync beats a coincident wrap: no tick is emitted.

Arithmetic:
- Comparisons are unsigned in DIV_W bits.
- div_act-1 never underflows because div_act>=2.

Optional Feature:
Macro BAUD_FRAC_EN.
- Defined:
  - Adds parameter FRAC_W (default 8) and input port frac_in [FRAC_W], loaded alongside div_in through the same pending/apply rules.
  - An FRAC_W-bit accumulator adds frac_act on every wrap. If the add carries out, the next period is div_act+1 cycles.
  - Average period is div_act + frac_act/2^FRAC_W.
  - Accumulator resets to 0 and is cleared by resync.
- Undefined: no frac_in port, no accumulator, integer periods only.

Decomposition:
- Package baud_pkg holds:
  - MIN_DIV=2.
  - Default DIV_W, OVERSAMPLE and FRAC_W constants.
  - Constant function calc_div(clk_hz, baud, oversample) returning the rounded divisor.
  - Localparam for the os_cnt width, log2(OVERSAMPLE).
- One sub-module, baud_prescaler, contains cnt, divisor staging, clamp and fractional accumulator, and outputs the wrap pulse and div_act.
- The top adds os_cnt and the bit/mid tick logic.

Test Plan:
- Reset then en=1 with defaults -> os_tick at cycles 651, 1302, 1953; bit_tick first at cycle 10416; mid_tick first at cycle 5208; div_cur=651 after reset.
- div_load with div_in=4 at cycle 300 -> next os_tick still at 651; later os_ticks at 655, 659, 663; div_cur changes to 4 at cycle 651.
- div_in=0 loaded, then resync -> div_cur=2, os_tick every 2 cycles, bit_tick every 32 cycles.
- Free-running at div=10; resync at cycle 25 -> no tick at cycle 30; os_tick at 35, 45; bit_tick exactly 160 cycles after the resync; mid_tick 80 cycles after the resync.
- en dropped for 7 cycles mid-period at div=10 -> tick period stretches to 17; no ticks while en=0; rst mid-count returns all outputs to 0 and div_cur to 651 on the next edge.
- With BAUD_FRAC_EN: div=651, frac_in=0x80 -> periods alternate 651/652 (average 651.5); frac_in=0 -> constant 651.

Source files
------------

// File: rtl/baud_tick_gen_pkg.sv
// Shared constants and helpers for the UART baud timing generator (package baud_pkg).
// Fractional-divisor support is enabled in the RTL by defining BAUD_FRAC_EN.
package baud_pkg;

    localparam int MIN_DIV        = 2;
    localparam int DEF_DIV_W      = 16;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_FRAC_W     = 8;

    // Rounded divisor: clk_hz / (baud * oversample), half-up.
    function automatic int calc_div(longint clk_hz, longint baud, longint oversample);
        longint den;
        den = baud * oversample;
        return int'((clk_hz + den / 2) / den);
    endfunction

    localparam int DEF_DIV  = calc_div(100_000_000, 9600, DEF_OVERSAMPLE);
    localparam int OS_CNT_W = $clog2(DEF_OVERSAMPLE);

endpackage

// File: rtl/baud_tick_gen_prescaler.sv
// Oversample prescaler: cycle counter, glitch-free divisor staging and clamp.
// With BAUD_FRAC_EN defined, adds a fractional accumulator that stretches periods by one cycle.
module baud_prescaler
    import baud_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
`ifdef BAUD_FRAC_EN
    parameter int FRAC_W      = DEF_FRAC_W,
`endif
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    input  logic             resync,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac_in,
`endif
    output logic             wrap,
    output logic [DIV_W-1:0] div_act
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_pend;
    logic [DIV_W-1:0] div_clamped;
    logic [DIV_W-1:0] term;
    logic             pend_valid;

    assign div_clamped = (div_in < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_in;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] frac_act;
    logic [FRAC_W-1:0] frac_pend;
    logic [FRAC_W:0]   acc_sum;
    logic              stretch;

    assign acc_sum = {1'b0, acc} + {1'b0, frac_act};
    // A carry out of the accumulator makes the following period one cycle longer.
    assign term    = stretch ? div_act : div_act - DIV_W'(1);
`else
    assign term    = div_act - DIV_W'(1);
`endif

    // Resync wins over a coincident wrap, so no tick leaks out on that edge.
    assign wrap = !rst && en && !resync && (cnt == term);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            div_act    <= DIV_W'(DEFAULT_DIV);
            div_pend   <= DIV_W'(DEFAULT_DIV);
            pend_valid <= 1'b0;
`ifdef BAUD_FRAC_EN
            acc        <= '0;
            frac_act   <= '0;
            frac_pend  <= '0;
            stretch    <= 1'b0;
`endif
        end else begin
            if (div_load) begin
                div_pend   <= div_clamped;
                pend_valid <= 1'b1;
`ifdef BAUD_FRAC_EN
                frac_pend  <= frac_in;
`endif
            end

            if (resync) begin
                cnt <= '0;
`ifdef BAUD_FRAC_EN
                acc     <= '0;
                stretch <= 1'b0;
`endif
                if (div_load) begin
                    div_act    <= div_clamped;
                    pend_valid <= 1'b0;
`ifdef BAUD_FRAC_EN
                    frac_act   <= frac_in;
`endif
                end else if (pend_valid) begin
                    div_act    <= div_pend;
                    pend_valid <= 1'b0;
`ifdef BAUD_FRAC_EN
                    frac_act   <= frac_pend;
`endif
                end
            end else if (en) begin
                if (wrap) begin
                    cnt <= '0;
`ifdef BAUD_FRAC_EN
                    acc     <= acc_sum[FRAC_W-1:0];
                    stretch <= acc_sum[FRAC_W];
`endif
                    // A load on this same edge stays pending for the next wrap.
                    if (pend_valid) begin
                        div_act    <= div_pend;
                        pend_valid <= div_load;
`ifdef BAUD_FRAC_EN
                        frac_act   <= frac_pend;
`endif
                    end
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// UART baud timing generator: oversample, bit-rate and mid-bit single-cycle enables.
// Define BAUD_FRAC_EN to add the fractional divisor input frac_in.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
`ifdef BAUD_FRAC_EN
    parameter int FRAC_W      = DEF_FRAC_W,
`endif
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    input  logic             resync,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac_in,
`endif
    output logic             os_tick,
    output logic             bit_tick,
    output logic             mid_tick,
    output logic [DIV_W-1:0] div_cur
);

    localparam int OSW = $clog2(OVERSAMPLE);

    logic           wrap;
    logic [OSW-1:0] os_cnt;

    baud_prescaler #(
        .DIV_W       (DIV_W),
`ifdef BAUD_FRAC_EN
        .FRAC_W      (FRAC_W),
`endif
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .resync   (resync),
`ifdef BAUD_FRAC_EN
        .frac_in  (frac_in),
`endif
        .wrap     (wrap),
        .div_act  (div_cur)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt   <= '0;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
        end else begin
            os_tick  <= wrap;
            bit_tick <= wrap && (os_cnt == OSW'(OVERSAMPLE - 1));
            mid_tick <= wrap && (os_cnt == OSW'(OVERSAMPLE / 2 - 1));
            if (resync) begin
                os_cnt <= '0;
            end else if (wrap) begin
                os_cnt <= os_cnt + OSW'(1);
            end
        end
    end

endmodule
